// File: rtl/y86_fde_if.sv
// Bus bundle for the Y86-64 fetch/decode/execute block: fetch address,
// instruction-memory load port, register-file read port and decoded results.
interface y86_fde_if;
  logic [63:0] pc;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [7:0]  imem_wdata;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valE;
  logic        cnd;
  logic [2:0]  cc;
  logic        instr_valid;
  logic        imem_error;
  logic        halt;

  modport master (
    output pc, imem_we, imem_waddr, imem_wdata, rd_a, rd_b,
    input  icode, ifun, rA, rB, valC, valP, src_a, src_b,
           valA, valB, valE, cnd, cc, instr_valid, imem_error, halt
  );

  modport slave (
    input  pc, imem_we, imem_waddr, imem_wdata, rd_a, rd_b,
    output icode, ifun, rA, rB, valC, valP, src_a, src_b,
           valA, valB, valE, cnd, cc, instr_valid, imem_error, halt
  );
endinterface

// File: rtl/y86_fde.sv
// Y86-64 sequential front half: byte-addressed instruction memory, fetch and
// split of the instruction at pc, register-source selection, ALU and the
// condition-code register. Everything except cc is combinational.
module y86_fde #(
  parameter int IMEM_BYTES = 1024
) (
  input logic     clk,
  input logic     rst_n,
  y86_fde_if.slave bus
);

  localparam int          AW        = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [63:0] IMEM_SIZE = 64'(IMEM_BYTES);

  logic [7:0]  mem_r [IMEM_BYTES];
  logic [2:0]  cc_r;
  logic [63:0] fetch_addr_s [10];
  logic [7:0]  byte_s [10];

  logic [3:0]  icode_raw_s, ifun_raw_s;
  logic        need_reg_s, icode_ok_s, ifun_ok_s;
  logic [1:0]  valc_pos_s;
  logic [3:0]  len_s;
  logic [63:0] last_addr_s;
  logic        imem_err_s;

  logic [3:0]  icode_s, ifun_s, ra_s, rb_s, src_a_s, src_b_s;
  logic [63:0] valc_s, valp_s, vala_s, valb_s, vale_s;
  logic        valid_s, halt_s, cnd_s, cc_load_s;
  logic        zf_s, sf_s, of_s, lt_s;

  // Byte-wide load port; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (bus.imem_we && (bus.imem_waddr < IMEM_SIZE)) begin
      mem_r[bus.imem_waddr[AW-1:0]] <= bus.imem_wdata;
    end
  end

  // Fetch window of 10 bytes starting at pc; bytes past the end read as zero.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      fetch_addr_s[k] = bus.pc + 64'(k);
      if (fetch_addr_s[k] < IMEM_SIZE) begin
        byte_s[k] = mem_r[fetch_addr_s[k][AW-1:0]];
      end else begin
        byte_s[k] = 8'h00;
      end
    end
  end

  // Instruction format: length, register byte, constant position, legality.
  always_comb begin
    icode_raw_s = byte_s[0][7:4];
    ifun_raw_s  = byte_s[0][3:0];
    need_reg_s  = 1'b0;
    valc_pos_s  = 2'd0;
    len_s       = 4'd1;
    icode_ok_s  = 1'b1;
    ifun_ok_s   = 1'b0;
    case (icode_raw_s)
      4'h0, 4'h1, 4'h9:       len_s = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: begin need_reg_s = 1'b1; len_s = 4'd2; end
      4'h3, 4'h4, 4'h5:       begin need_reg_s = 1'b1; valc_pos_s = 2'd2; len_s = 4'd10; end
      4'h7, 4'h8:             begin valc_pos_s = 2'd1; len_s = 4'd9; end
      default:                icode_ok_s = 1'b0;
    endcase
    case (icode_raw_s)
      4'h2, 4'h7: ifun_ok_s = (ifun_raw_s <= 4'd6);
      4'h6:       ifun_ok_s = (ifun_raw_s <= 4'd3);
      default:    ifun_ok_s = (ifun_raw_s == 4'd0);
    endcase
    // pc below the memory size means the last-byte sum cannot wrap.
    last_addr_s = bus.pc + 64'(len_s) - 64'd1;
    imem_err_s  = (bus.pc >= IMEM_SIZE) || (last_addr_s >= IMEM_SIZE);
  end

  // Decoded fields; a fetch error blanks everything and parks valP at pc.
  always_comb begin
    if (imem_err_s) begin
      icode_s = 4'h0;
      ifun_s  = 4'h0;
      ra_s    = 4'h0;
      rb_s    = 4'h0;
      valc_s  = 64'd0;
      valp_s  = bus.pc;
      valid_s = 1'b0;
      halt_s  = 1'b0;
    end else begin
      icode_s = icode_raw_s;
      ifun_s  = ifun_raw_s;
      ra_s    = need_reg_s ? byte_s[1][7:4] : 4'hF;
      rb_s    = need_reg_s ? byte_s[1][3:0] : 4'hF;
      case (valc_pos_s)
        2'd1:    valc_s = {byte_s[8], byte_s[7], byte_s[6], byte_s[5],
                           byte_s[4], byte_s[3], byte_s[2], byte_s[1]};
        2'd2:    valc_s = {byte_s[9], byte_s[8], byte_s[7], byte_s[6],
                           byte_s[5], byte_s[4], byte_s[3], byte_s[2]};
        default: valc_s = 64'd0;
      endcase
      valp_s  = bus.pc + 64'(len_s);
      valid_s = icode_ok_s && ifun_ok_s;
      halt_s  = (icode_raw_s == 4'h0);
    end
  end

  // Register-file sources and operand values (absent source reads as 0).
  always_comb begin
    case (icode_s)
      4'h2, 4'h4, 4'h6, 4'hA: src_a_s = ra_s;
      4'h9, 4'hB:             src_a_s = 4'h4;
      default:                src_a_s = 4'hF;
    endcase
    case (icode_s)
      4'h4, 4'h5, 4'h6:       src_b_s = rb_s;
      4'h8, 4'h9, 4'hA, 4'hB: src_b_s = 4'h4;
      default:                src_b_s = 4'hF;
    endcase
    vala_s = (src_a_s != 4'hF) ? bus.rd_a : 64'd0;
    valb_s = (src_b_s != 4'hF) ? bus.rd_b : 64'd0;
  end

  // ALU result and the OPq flags it would produce.
  always_comb begin
    case (icode_s)
      4'h2:       vale_s = vala_s;
      4'h3:       vale_s = valc_s;
      4'h4, 4'h5: vale_s = valb_s + valc_s;
      4'h6: begin
        case (ifun_s)
          4'h0:    vale_s = valb_s + vala_s;
          4'h1:    vale_s = valb_s - vala_s;
          4'h2:    vale_s = valb_s & vala_s;
          4'h3:    vale_s = valb_s ^ vala_s;
          default: vale_s = 64'd0;
        endcase
      end
      4'h8, 4'hA: vale_s = valb_s - 64'd8;
      4'h9, 4'hB: vale_s = valb_s + 64'd8;
      default:    vale_s = 64'd0;
    endcase
    zf_s = (vale_s == 64'd0);
    sf_s = vale_s[63];
    case (ifun_s)
      4'h0:    of_s = (vala_s[63] == valb_s[63]) && (vale_s[63] != vala_s[63]);
      4'h1:    of_s = (valb_s[63] != vala_s[63]) && (vale_s[63] != valb_s[63]);
      default: of_s = 1'b0;
    endcase
    cc_load_s = (icode_s == 4'h6) && valid_s && !imem_err_s;
  end

  // Branch / conditional-move condition from the registered flags.
  always_comb begin
    lt_s = cc_r[1] ^ cc_r[0];
    if ((icode_s == 4'h2) || (icode_s == 4'h7)) begin
      case (ifun_s)
        4'h0:    cnd_s = 1'b1;
        4'h1:    cnd_s = lt_s | cc_r[2];
        4'h2:    cnd_s = lt_s;
        4'h3:    cnd_s = cc_r[2];
        4'h4:    cnd_s = ~cc_r[2];
        4'h5:    cnd_s = ~lt_s;
        4'h6:    cnd_s = ~lt_s & ~cc_r[2];
        default: cnd_s = 1'b0;
      endcase
    end else begin
      cnd_s = 1'b0;
    end
  end

  // Condition codes {ZF, SF, OF}: load on a legal OPq, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_r <= 3'b100;
    end else if (cc_load_s) begin
      cc_r <= {zf_s, sf_s, of_s};
    end else begin
      cc_r <= cc_r;
    end
  end

  assign bus.icode       = icode_s;
  assign bus.ifun        = ifun_s;
  assign bus.rA          = ra_s;
  assign bus.rB          = rb_s;
  assign bus.valC        = valc_s;
  assign bus.valP        = valp_s;
  assign bus.src_a       = src_a_s;
  assign bus.src_b       = src_b_s;
  assign bus.valA        = vala_s;
  assign bus.valB        = valb_s;
  assign bus.valE        = vale_s;
  assign bus.cnd         = cnd_s;
  assign bus.cc          = cc_r;
  assign bus.instr_valid = valid_s;
  assign bus.imem_error  = imem_err_s;
  assign bus.halt        = halt_s;

endmodule

// File: tb/tb_y86_fde.sv
// Randomized bench for y86_fde against an instruction-level reference model.
module tb_y86_fde;

  localparam int IMEM = 1024;

  typedef struct packed {
    logic [3:0]  icode, ifun, ra, rb, src_a, src_b;
    logic [63:0] valc, valp, vala, valb, vale;
    logic        cnd, valid, err, halt;
    logic [2:0]  ccn;
  } exp_t;

  logic clk;
  logic rst_n;
  y86_fde_if bus ();

  y86_fde #(.IMEM_BYTES(IMEM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem_m [IMEM];
  logic [2:0] cc_m;
  exp_t       exp_last;
  int         n_vec;
  int         n_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference: decode the instruction straight from the memory image.
  function automatic exp_t model(input logic [63:0] pc_v, input logic [63:0] ra_d,
                                 input logic [63:0] rb_d, input logic [2:0] ccv);
    exp_t        e;
    logic [7:0]  b [10];
    logic [63:0] a;
    logic [64:0] w;
    logic [3:0]  ic, fn;
    int          len;
    logic        has_reg, zf, sf, ovf, lt;
    e = '0;
    for (int k = 0; k < 10; k++) begin
      a = pc_v + 64'(k);
      b[k] = (a < 64'(IMEM)) ? mem_m[a[9:0]] : 8'h00;
    end
    ic = b[0][7:4];
    fn = b[0][3:0];
    if (ic inside {4'h0, 4'h1, 4'h9}) len = 1;
    else if (ic inside {4'h2, 4'h6, 4'hA, 4'hB}) len = 2;
    else if (ic inside {4'h3, 4'h4, 4'h5}) len = 10;
    else if (ic inside {4'h7, 4'h8}) len = 9;
    else len = 1;
    e.valp  = pc_v;
    e.src_a = 4'hF;
    e.src_b = 4'hF;
    e.ccn   = ccv;
    if (pc_v >= 64'(IMEM) || pc_v + 64'(len) > 64'(IMEM)) begin
      e.err = 1'b1;
      return e;
    end
    e.icode = ic;
    e.ifun  = fn;
    e.halt  = (ic == 4'h0);
    e.valp  = pc_v + 64'(len);
    has_reg = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    e.ra = has_reg ? b[1][7:4] : 4'hF;
    e.rb = has_reg ? b[1][3:0] : 4'hF;
    for (int j = 0; j < 8; j++) begin
      if (ic inside {4'h3, 4'h4, 4'h5}) e.valc[8*j +: 8] = b[2+j];
      else if (ic inside {4'h7, 4'h8}) e.valc[8*j +: 8] = b[1+j];
    end
    if (ic > 4'hB) e.valid = 1'b0;
    else if (ic == 4'h2 || ic == 4'h7) e.valid = (fn <= 4'd6);
    else if (ic == 4'h6) e.valid = (fn <= 4'd3);
    else e.valid = (fn == 4'd0);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) e.src_a = e.ra;
    else if (ic inside {4'h9, 4'hB}) e.src_a = 4'h4;
    if (ic inside {4'h4, 4'h5, 4'h6}) e.src_b = e.rb;
    else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) e.src_b = 4'h4;
    e.vala = (e.src_a == 4'hF) ? 64'd0 : ra_d;
    e.valb = (e.src_b == 4'hF) ? 64'd0 : rb_d;
    e.vale = 64'd0;
    ovf = 1'b0;
    if (ic == 4'h2) e.vale = e.vala;
    else if (ic == 4'h3) e.vale = e.valc;
    else if (ic == 4'h4 || ic == 4'h5) e.vale = e.valb + e.valc;
    else if (ic == 4'h8 || ic == 4'hA) e.vale = e.valb - 64'd8;
    else if (ic == 4'h9 || ic == 4'hB) e.vale = e.valb + 64'd8;
    else if (ic == 4'h6) begin
      // Signed overflow: the 65-bit sign-extended result does not fit 64 bits.
      if (fn == 4'd0) begin
        w = {e.valb[63], e.valb} + {e.vala[63], e.vala};
        e.vale = w[63:0];
        ovf = w[64] ^ w[63];
      end else if (fn == 4'd1) begin
        w = {e.valb[63], e.valb} - {e.vala[63], e.vala};
        e.vale = w[63:0];
        ovf = w[64] ^ w[63];
      end else if (fn == 4'd2) e.vale = e.valb & e.vala;
      else if (fn == 4'd3) e.vale = e.valb ^ e.vala;
    end
    zf = (e.vale == 64'd0);
    sf = e.vale[63];
    if (ic == 4'h6 && e.valid) e.ccn = {zf, sf, ovf};
    lt = ccv[1] ^ ccv[0];
    if (ic == 4'h2 || ic == 4'h7) begin
      case (fn)
        4'd0:    e.cnd = 1'b1;
        4'd1:    e.cnd = lt | ccv[2];
        4'd2:    e.cnd = lt;
        4'd3:    e.cnd = ccv[2];
        4'd4:    e.cnd = !ccv[2];
        4'd5:    e.cnd = !lt;
        4'd6:    e.cnd = !lt && !ccv[2];
        default: e.cnd = 1'b0;
      endcase
    end
    return e;
  endfunction

  task automatic wr_byte(input logic [63:0] addr, input logic [7:0] data);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = addr;
    bus.imem_wdata = data;
    @(posedge clk);
    #1;
    bus.imem_we = 1'b0;
    if (addr < 64'(IMEM)) mem_m[addr[9:0]] = data;
  endtask

  task automatic step(input logic [63:0] pc_v, input logic [63:0] a_v, input logic [63:0] b_v);
    bus.pc   = pc_v;
    bus.rd_a = a_v;
    bus.rd_b = b_v;
    @(negedge clk);
    exp_last = model(pc_v, a_v, b_v, cc_m);
    check_eq("icode", 64'(bus.icode), 64'(exp_last.icode));
    check_eq("ifun", 64'(bus.ifun), 64'(exp_last.ifun));
    check_eq("rA", 64'(bus.rA), 64'(exp_last.ra));
    check_eq("rB", 64'(bus.rB), 64'(exp_last.rb));
    check_eq("valC", bus.valC, exp_last.valc);
    check_eq("valP", bus.valP, exp_last.valp);
    check_eq("src_a", 64'(bus.src_a), 64'(exp_last.src_a));
    check_eq("src_b", 64'(bus.src_b), 64'(exp_last.src_b));
    check_eq("valA", bus.valA, exp_last.vala);
    check_eq("valB", bus.valB, exp_last.valb);
    check_eq("valE", bus.valE, exp_last.vale);
    check_eq("cnd", 64'(bus.cnd), 64'(exp_last.cnd));
    check_eq("instr_valid", 64'(bus.instr_valid), 64'(exp_last.valid));
    check_eq("imem_error", 64'(bus.imem_error), 64'(exp_last.err));
    check_eq("halt", 64'(bus.halt), 64'(exp_last.halt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) cc_m = exp_last.ccn;
    check_eq("cc", 64'(bus.cc), 64'(cc_m));
  endtask

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'($urandom_range(0, 16));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] pc_v;
    logic [3:0]  ic, fn;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    cc_m  = 3'b100;
    bus.pc = 64'd0;
    bus.rd_a = 64'd0;
    bus.rd_b = 64'd0;
    bus.imem_we = 1'b0;
    bus.imem_waddr = 64'd0;
    bus.imem_wdata = 8'h00;
    @(posedge clk);
    #1;
    for (int i = 0; i < IMEM; i++) wr_byte(64'(i), 8'h00);
    wr_byte(64'd0, 8'h30);  wr_byte(64'd1, 8'hF3);  wr_byte(64'd2, 8'h0A);
    wr_byte(64'd10, 8'h60); wr_byte(64'd11, 8'h23);
    wr_byte(64'd12, 8'h61); wr_byte(64'd13, 8'h11);
    wr_byte(64'd14, 8'h71); wr_byte(64'd15, 8'h40);
    wr_byte(64'd23, 8'h74); wr_byte(64'd24, 8'h40);
    wr_byte(64'd32, 8'hA0); wr_byte(64'd33, 8'h4F);
    wr_byte(64'd34, 8'hB0); wr_byte(64'd35, 8'h4F);
    wr_byte(64'd36, 8'hC0);
    wr_byte(64'd1022, 8'h30); wr_byte(64'd1023, 8'hF3);

    // Reset state with pc on a zero byte.
    step(64'd100, 64'd0, 64'd0);
    check_eq("rst_cc", 64'(bus.cc), 64'(3'b100));
    check_eq("rst_halt", 64'(bus.halt), 64'd1);
    check_eq("rst_valP", bus.valP, 64'd101);
    check_eq("rst_valE", bus.valE, 64'd0);
    check_eq("rst_cnd", 64'(bus.cnd), 64'd0);
    tick();
    rst_n = 1'b1;

    step(64'd0, 64'd7, 64'd9);
    check_eq("irm_icode", 64'(bus.icode), 64'h3);
    check_eq("irm_rA", 64'(bus.rA), 64'hF);
    check_eq("irm_rB", 64'(bus.rB), 64'h3);
    check_eq("irm_valC", bus.valC, 64'd10);
    check_eq("irm_valP", bus.valP, 64'd10);
    check_eq("irm_valE", bus.valE, 64'd10);
    check_eq("irm_src_a", 64'(bus.src_a), 64'hF);
    check_eq("irm_src_b", 64'(bus.src_b), 64'hF);
    tick();

    step(64'd10, 64'd2, 64'd3);
    check_eq("add_src_a", 64'(bus.src_a), 64'h2);
    check_eq("add_src_b", 64'(bus.src_b), 64'h3);
    check_eq("add_valE", bus.valE, 64'd5);
    check_eq("add_valP", bus.valP, 64'd12);
    tick();
    check_eq("add_cc", 64'(bus.cc), 64'(3'b000));

    step(64'd12, 64'd1, 64'd1);
    check_eq("sub_valE", bus.valE, 64'd0);
    tick();
    check_eq("sub_cc", 64'(bus.cc), 64'(3'b100));

    step(64'd14, 64'd0, 64'd0);
    check_eq("jle_valC", bus.valC, 64'h40);
    check_eq("jle_valP", bus.valP, 64'd23);
    check_eq("jle_cnd", 64'(bus.cnd), 64'd1);
    tick();
    step(64'd23, 64'd0, 64'd0);
    check_eq("jne_cnd", 64'(bus.cnd), 64'd0);
    tick();

    step(64'd32, 64'd4, 64'd4);
    check_eq("push_src_a", 64'(bus.src_a), 64'h4);
    check_eq("push_src_b", 64'(bus.src_b), 64'h4);
    check_eq("push_valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check_eq("push_cc", 64'(bus.cc), 64'(3'b100));
    step(64'd34, 64'd4, 64'd4);
    check_eq("pop_valE", bus.valE, 64'd12);
    tick();
    check_eq("pop_cc", 64'(bus.cc), 64'(3'b100));

    step(64'd36, 64'd0, 64'd0);
    check_eq("bad_valid", 64'(bus.instr_valid), 64'd0);
    tick();
    check_eq("bad_cc", 64'(bus.cc), 64'(3'b100));
    step(64'd1022, 64'd0, 64'd0);
    check_eq("err_flag", 64'(bus.imem_error), 64'd1);
    tick();
    check_eq("err_cc", 64'(bus.cc), 64'(3'b100));

    // Random instructions at random addresses, including past the memory end.
    for (int it = 0; it < 200; it++) begin
      ic = 4'($urandom_range(0, 13));
      if ($urandom_range(0, 3) == 0) fn = 4'($urandom_range(0, 15));
      else if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
      else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
      else fn = 4'h0;
      if ($urandom_range(0, 19) == 0) pc_v = {32'hFFFF_FFFF, $urandom};
      else pc_v = 64'($urandom_range(0, IMEM + 9));
      wr_byte(pc_v, {ic, fn});
      for (int k = 1; k < 10; k++) wr_byte(pc_v + 64'(k), 8'($urandom));
      step(pc_v, pick64(), pick64());
      tick();
    end

    // Asynchronous reset mid-cycle: cc clears at once, decode keeps going.
    wr_byte(64'd200, 8'h60);
    wr_byte(64'd201, 8'h23);
    step(64'd200, 64'd2, 64'd3);
    tick();
    #2;
    rst_n = 1'b0;
    cc_m  = 3'b100;
    #1;
    check_eq("async_cc", 64'(bus.cc), 64'(3'b100));
    check_eq("async_valP", bus.valP, 64'd202);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
